rtc_clock: RTL and testbench
============================

# rtc_clock

Parametrised successor of the single-rate HH:MM:SS clock: a BCD real-time clock with a configurable clock-per-second prescaler, run-time 12/24-hour display mode, a synchronous time-load port with validity checking, and a sticky HH:MM alarm. Time is held internally in 24-hour BCD and converted for display. It sits between the system clock domain and the display/control logic of the digital clock subsystem.

## Interface
- CLKS_PER_SEC, default 1, i_clk cycles per second tick; legal range ≥1.
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_en  in  1  count enable; low freezes prescaler and time.
- i_mode_24  in  1  1 = 24-hour display, 0 = 12-hour display with AM/PM.
- i_ld  in  1  one-cycle load strobe for the time.
- i_ld_hh / i_ld_mm / i_ld_ss  in  8 each  load value, 24-hour BCD.
- i_alm_wr  in  1  one-cycle strobe to write the alarm time.
- i_alm_hh / i_alm_mm  in  8 each  alarm time, 24-hour BCD.
- i_alm_en  in  1  alarm arm.
- i_alm_ack  in  1  clears o_alarm.
- o_hh / o_mm / o_ss  out  8 each  displayed time, BCD.
- o_pm  out  1  1 when internal hour ≥ 0x12; valid in both modes.
- o_tick  out  1  one-cycle pulse on each second advance.
- o_alarm  out  1  sticky alarm flag.
- o_ld_err  out  1  one-cycle pulse when a load or alarm write is rejected.

## Operation
- Prescaler: counter of width max(1,$clog2(CLKS_PER_SEC)) counts 0..CLKS_PER_SEC-1 while i_en=1. The tick fires on the cycle where the counter equals CLKS_PER_SEC-1, and the counter then wraps to 0. With CLKS_PER_SEC=1, every enabled cycle is a tick.
- Tick advances the time in BCD:
  - ss 0x59 → 0x00 and carry into mm.
  - mm 0x59 → 0x00 and carry into hh.
  - hh 0x23 → 0x00.
  - Each nibble rolls 9 → 0 with carry to the next nibble.
- Validity: a value is valid only if every nibble ≤ 9, hh ≤ 0x23, mm ≤ 0x59, and ss ≤ 0x59.
- Load:
  - i_ld with valid values overwrites hh/mm/ss and clears the prescaler to 0.
  - Invalid values leave all state unchanged and pulse o_ld_err.
  - Load has priority over a tick in the same cycle; that tick is discarded.
  - Load works regardless of i_en.
- Alarm write: i_alm_wr with valid i_alm_hh/mm stores the alarm; an invalid write pulses o_ld_err and keeps the old alarm.
- Alarm match:
  - o_alarm sets when a tick produces a time equal to alarm_hh:alarm_mm:00 while i_alm_en=1.
  - A load never triggers the alarm.
  - i_alm_ack clears o_alarm. If set and ack coincide, set wins.
  - Deasserting i_alm_en does not clear an already-set o_alarm.
- Display conversion is combinational from the internal registers:
  - 24-hour mode: o_hh equals the internal hour.
  - 12-hour mode: hour 0x00 → 0x12; 0x01–0x12 unchanged; 0x13–0x23 → hour minus 12, in BCD (0x13→0x01 … 0x23→0x11).
  - o_mm and o_ss pass through unchanged in both modes.

## Timing
- Reset (i_rst=0, asynchronous):
  - Internal time is 00:00:00, the prescaler is 0, the alarm register is 00:00, and o_alarm=0.
  - Outputs: o_tick=0, o_ld_err=0, o_pm=0. o_hh=0x00 in 24-hour mode, 0x12 in 12-hour mode. o_mm=o_ss=0x00.
- The first tick occurs CLKS_PER_SEC enabled cycles after release of reset.
- o_tick is registered and coincides with the cycle the new time is visible; one-cycle latency from the prescaler-wrap edge.
- Load, alarm write and alarm set each take effect on the rising edge where the strobe is sampled, and are visible in the following cycle. o_ld_err follows the same timing.
- i_mode_24 changes are visible immediately at the outputs; internal time is unaffected.
- i_en=0 on the would-be tick cycle suppresses the tick; the prescaler holds its value.
- Reset asserted mid-count or mid-load aborts it immediately, with no partial update.

## Test plan
- Reset release, CLKS_PER_SEC=4, i_en=1, 24-hour mode → o_tick on cycles 4, 8, 12; time reads 00:00:01, 00:00:02, 00:00:03.
- Load 23:59:58, CLKS_PER_SEC=1 → two ticks later 00:00:00, o_pm falls 1→0; in 12-hour mode the display reads 12:00:00 with o_pm=0.
- 12-hour mode, load 12:59:59 → next tick shows 01:00:00, o_pm=1; then load 13:00:00 → shows 01:00:00, o_pm=1.
- Load 0x24:00:00, then 10:0x5A:00 → o_ld_err pulses each time and time is unchanged; a valid load coinciding with a tick → loaded value held with no increment.
- Alarm 07:30, i_alm_en=1, load 07:29:59 → next tick o_alarm=1 and it stays set; i_alm_ack → 0. Loading 07:30:00 directly → no alarm.
- i_en low for 10 cycles mid-second → the prescaler and time freeze, and counting resumes from the held value.

Source files
------------

// File: rtl/rtc_clock.sv
// rtc_clock: BCD real-time clock with a clocks-per-second prescaler, run-time
// 12/24-hour display, a validated time-load port and a sticky HH:MM alarm.
// Time is kept internally in 24-hour BCD and converted for display.
module rtc_clock #(
  parameter int CLKS_PER_SEC = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_mode_24,
  input  logic       i_ld,
  input  logic [7:0] i_ld_hh,
  input  logic [7:0] i_ld_mm,
  input  logic [7:0] i_ld_ss,
  input  logic       i_alm_wr,
  input  logic [7:0] i_alm_hh,
  input  logic [7:0] i_alm_mm,
  input  logic       i_alm_en,
  input  logic       i_alm_ack,
  output logic [7:0] o_hh,
  output logic [7:0] o_mm,
  output logic [7:0] o_ss,
  output logic       o_pm,
  output logic       o_tick,
  output logic       o_alarm,
  output logic       o_ld_err
);

  localparam int PW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_SEC - 1);

  // True when both nibbles are decimal digits and the value does not exceed lim.
  // With valid nibbles, BCD values order the same way as their binary codes.
  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] lim);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= lim);
  endfunction

  // Returns {carry, next}: wraps to 0x00 with carry at lim, otherwise a BCD +1.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    if (v == lim)             return {1'b1, 8'h00};
    else if (v[3:0] == 4'd9)  return {1'b0, v[7:4] + 4'd1, 4'd0};
    else                      return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  logic [PW-1:0] presc;
  logic [7:0]    hh, mm, ss;
  logic [7:0]    alm_hh, alm_mm;
  logic          ld_ok, alm_ok, wrap, do_tick, alarm_hit;
  logic [8:0]    ss_inc, mm_inc, hh_inc;
  logic [7:0]    nxt_hh, nxt_mm, nxt_ss;
  logic [4:0]    hr_bin, h12;

  assign ld_ok   = bcd_ok(i_ld_hh, 8'h23) && bcd_ok(i_ld_mm, 8'h59) && bcd_ok(i_ld_ss, 8'h59);
  assign alm_ok  = bcd_ok(i_alm_hh, 8'h23) && bcd_ok(i_alm_mm, 8'h59);
  assign wrap    = i_en && (presc == PRESC_MAX);
  // Any load strobe owns the cycle: a valid load replaces the tick, a rejected
  // one leaves every register untouched.
  assign do_tick = wrap && !i_ld;

  assign ss_inc = bcd_inc(ss, 8'h59);
  assign mm_inc = bcd_inc(mm, 8'h59);
  assign hh_inc = bcd_inc(hh, 8'h23);

  // Time one second ahead of the current registers, with the carry chain.
  always_comb begin
    nxt_ss = ss_inc[7:0];
    nxt_mm = ss_inc[8] ? mm_inc[7:0] : mm;
    nxt_hh = (ss_inc[8] && mm_inc[8]) ? hh_inc[7:0] : hh;
  end

  assign alarm_hit = do_tick && i_alm_en && (nxt_hh == alm_hh) && (nxt_mm == alm_mm) &&
                     (nxt_ss == 8'h00);

  // Prescaler and time registers: load first, otherwise count while enabled.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values and simulation matches the synthesized hardware.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      presc <= '0;
      hh    <= 8'h00;
      mm    <= 8'h00;
      ss    <= 8'h00;
    end else if (i_ld) begin
      if (ld_ok) begin
        presc <= '0;
        hh    <= i_ld_hh;
        mm    <= i_ld_mm;
        ss    <= i_ld_ss;
      end
    end else if (i_en) begin
      if (wrap) begin
        presc <= '0;
        hh    <= nxt_hh;
        mm    <= nxt_mm;
        ss    <= nxt_ss;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // Alarm register: only a fully valid HH:MM replaces the stored alarm.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      alm_hh <= 8'h00;
      alm_mm <= 8'h00;
    end else if (i_alm_wr && alm_ok) begin
      alm_hh <= i_alm_hh;
      alm_mm <= i_alm_mm;
    end
  end

  // Registered status: tick pulse, rejected-write pulse and sticky alarm (set wins over ack).
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_tick   <= 1'b0;
      o_ld_err <= 1'b0;
      o_alarm  <= 1'b0;
    end else begin
      o_tick   <= do_tick;
      o_ld_err <= (i_ld && !ld_ok) || (i_alm_wr && !alm_ok);
      o_alarm  <= alarm_hit || (o_alarm && !i_alm_ack);
    end
  end

  // Display conversion from the internal 24-hour registers.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    hr_bin = 5'(hh[7:4]) * 5'd10 + 5'(hh[3:0]);
    h12    = hr_bin - 5'd12;
    o_hh   = hh;
    if (!i_mode_24) begin
      if (hh == 8'h00) begin
        o_hh = 8'h12;
      end else if (hh > 8'h12) begin
        o_hh = (h12 >= 5'd10) ? {4'd1, 4'(h12 - 5'd10)} : {4'd0, h12[3:0]};
      end
    end
  end

  assign o_mm = mm;
  assign o_ss = ss;
  assign o_pm = (hh >= 8'h12);

endmodule

// File: tb/tb_rtc_clock.sv
// tb_rtc_clock: two rtc_clock instances (4 and 1 clocks per second) driven by
// shared directed stimulus, checked every cycle against a seconds-of-day model
// plus hand-computed literal expectations.
module tb_rtc_clock;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, mode_24, ld, alm_wr, alm_en, alm_ack;
  logic [7:0] ld_hh, ld_mm, ld_ss, alm_hh, alm_mm;
  logic [7:0] hh [2];
  logic [7:0] mm [2];
  logic [7:0] ss [2];
  logic       pm [2];
  logic       tick [2];
  logic       alarm [2];
  logic       ld_err [2];

  rtc_clock #(.CLKS_PER_SEC(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode_24(mode_24),
    .i_ld(ld), .i_ld_hh(ld_hh), .i_ld_mm(ld_mm), .i_ld_ss(ld_ss),
    .i_alm_wr(alm_wr), .i_alm_hh(alm_hh), .i_alm_mm(alm_mm),
    .i_alm_en(alm_en), .i_alm_ack(alm_ack),
    .o_hh(hh[0]), .o_mm(mm[0]), .o_ss(ss[0]), .o_pm(pm[0]),
    .o_tick(tick[0]), .o_alarm(alarm[0]), .o_ld_err(ld_err[0])
  );

  rtc_clock #(.CLKS_PER_SEC(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode_24(mode_24),
    .i_ld(ld), .i_ld_hh(ld_hh), .i_ld_mm(ld_mm), .i_ld_ss(ld_ss),
    .i_alm_wr(alm_wr), .i_alm_hh(alm_hh), .i_alm_mm(alm_mm),
    .i_alm_en(alm_en), .i_alm_ack(alm_ack),
    .o_hh(hh[1]), .o_mm(mm[1]), .o_ss(ss[1]), .o_pm(pm[1]),
    .o_tick(tick[1]), .o_alarm(alarm[1]), .o_ld_err(ld_err[1])
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  // Model state: seconds of day, prescaler count, alarm minute of day, flags.
  int m_secs [2];
  int m_pre  [2];
  int m_alm  [2];
  bit m_alarm [2];
  bit m_tick  [2];
  bit m_err   [2];

  function automatic int period(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic int bcd_val(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic bit bcd_valid(input logic [7:0] v, input int lim);
    return (int'(v[7:4]) <= 9) && (int'(v[3:0]) <= 9) && (bcd_val(v) <= lim);
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    return 8'((n / 10) * 16 + (n % 10));
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: advances on each clock edge, clears on reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        m_secs[k] = 0; m_pre[k] = 0; m_alm[k] = 0;
        m_alarm[k] = 0; m_tick[k] = 0; m_err[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit set;
        set = 0;
        m_err[k] = 0;
        m_tick[k] = 0;
        if (ld) begin
          if (bcd_valid(ld_hh, 23) && bcd_valid(ld_mm, 59) && bcd_valid(ld_ss, 59)) begin
            m_secs[k] = bcd_val(ld_hh) * 3600 + bcd_val(ld_mm) * 60 + bcd_val(ld_ss);
            m_pre[k]  = 0;
          end else begin
            m_err[k] = 1;
          end
        end else if (en) begin
          if (m_pre[k] == period(k) - 1) begin
            m_pre[k]  = 0;
            m_secs[k] = (m_secs[k] + 1) % 86400;
            m_tick[k] = 1;
            set = alm_en && (m_secs[k] == m_alm[k] * 60);
          end else begin
            m_pre[k]++;
          end
        end
        if (alm_wr) begin
          if (bcd_valid(alm_hh, 23) && bcd_valid(alm_mm, 59))
            m_alm[k] = bcd_val(alm_hh) * 60 + bcd_val(alm_mm);
          else
            m_err[k] = 1;
        end
        m_alarm[k] = set || (m_alarm[k] && !alm_ack);
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      for (int k = 0; k < 2; k++) begin
        int h, d;
        h = m_secs[k] / 3600;
        d = mode_24 ? h : (((h % 12) == 0) ? 12 : (h % 12));
        check($sformatf("cyc_hh[%0d]", k), hh[k], to_bcd(d));
        check($sformatf("cyc_mm[%0d]", k), mm[k], to_bcd((m_secs[k] / 60) % 60));
        check($sformatf("cyc_ss[%0d]", k), ss[k], to_bcd(m_secs[k] % 60));
        check($sformatf("cyc_pm[%0d]", k), 8'(pm[k]), 8'(h >= 12));
        check($sformatf("cyc_tick[%0d]", k), 8'(tick[k]), 8'(m_tick[k]));
        check($sformatf("cyc_alarm[%0d]", k), 8'(alarm[k]), 8'(m_alarm[k]));
        check($sformatf("cyc_err[%0d]", k), 8'(ld_err[k]), 8'(m_err[k]));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    ld_hh = h; ld_mm = m; ld_ss = s; ld = 1'b1;
    cyc(1);
    ld = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; mode_24 = 1'b1; ld = 1'b0; alm_wr = 1'b0;
    alm_en = 1'b0; alm_ack = 1'b0;
    ld_hh = 8'h00; ld_mm = 8'h00; ld_ss = 8'h00; alm_hh = 8'h00; alm_mm = 8'h00;
    cyc(2);
    cmp_on = 1'b1;

    // Reset state in both display modes
    check("rst_hh24", hh[0], 8'h00);
    check("rst_ss", ss[0], 8'h00);
    check("rst_tick", 8'(tick[0]), 8'h00);
    mode_24 = 1'b0;
    #1;
    check("rst_hh12", hh[0], 8'h12);
    check("rst_pm12", 8'(pm[0]), 8'h00);
    mode_24 = 1'b1;
    rst = 1'b1;

    // First ticks at 4, 8, 12 cycles after reset release
    for (int i = 1; i <= 3; i++) begin
      cyc(3);
      check("pre_tick_low", 8'(tick[0]), 8'h00);
      cyc(1);
      check("tick_high", 8'(tick[0]), 8'h01);
      check("tick_ss", ss[0], 8'(i));
    end
    check("fast_ss12", ss[1], 8'h12);

    // Midnight rollover and 12-hour display of midnight
    load(8'h23, 8'h59, 8'h58);
    check("ld_hh23", hh[1], 8'h23);
    check("ld_pm", 8'(pm[1]), 8'h01);
    cyc(2);
    check("mid_hh", hh[1], 8'h00);
    check("mid_mm", mm[1], 8'h00);
    check("mid_ss", ss[1], 8'h00);
    check("mid_pm", 8'(pm[1]), 8'h00);
    mode_24 = 1'b0;
    #1;
    check("mid_hh12", hh[1], 8'h12);

    // 12-hour display around noon
    load(8'h12, 8'h59, 8'h59);
    check("noon_hh12", hh[1], 8'h12);
    cyc(1);
    check("one_pm_hh", hh[1], 8'h01);
    check("one_pm_pm", 8'(pm[1]), 8'h01);
    load(8'h13, 8'h00, 8'h00);
    check("ld13_hh4", hh[0], 8'h01);
    check("ld13_ss4", ss[0], 8'h00);
    check("ld13_hh1", hh[1], 8'h01);
    check("ld13_ss1", ss[1], 8'h00);

    // Rejected loads with counting frozen; valid load beats a tick
    mode_24 = 1'b1;
    en = 1'b0;
    load(8'h10, 8'h20, 8'h30);
    load(8'h24, 8'h00, 8'h00);
    check("bad_hh_err", 8'(ld_err[1]), 8'h01);
    check("bad_hh_keep", hh[1], 8'h10);
    check("bad_hh_ss", ss[1], 8'h30);
    cyc(1);
    check("err_clear", 8'(ld_err[1]), 8'h00);
    load(8'h10, 8'h5A, 8'h00);
    check("bad_mm_err", 8'(ld_err[1]), 8'h01);
    check("bad_mm_keep", mm[1], 8'h20);
    en = 1'b1;
    load(8'h05, 8'h06, 8'h07);
    check("ld_wins_ss", ss[1], 8'h07);
    check("ld_wins_tick", 8'(tick[1]), 8'h00);

    // Alarm set, hold, acknowledge; direct load does not trigger
    alm_hh = 8'h07; alm_mm = 8'h30; alm_wr = 1'b1; alm_en = 1'b1;
    load(8'h07, 8'h29, 8'h59);
    alm_wr = 1'b0;
    check("alm_pre", 8'(alarm[1]), 8'h00);
    cyc(1);
    check("alm_set", 8'(alarm[1]), 8'h01);
    cyc(3);
    check("alm_sticky", 8'(alarm[1]), 8'h01);
    check("alm_set4", 8'(alarm[0]), 8'h01);
    alm_ack = 1'b1;
    cyc(1);
    alm_ack = 1'b0;
    check("alm_ack1", 8'(alarm[1]), 8'h00);
    check("alm_ack4", 8'(alarm[0]), 8'h00);
    alm_hh = 8'h07; alm_mm = 8'h60; alm_wr = 1'b1;
    cyc(1);
    alm_wr = 1'b0;
    check("alm_bad_err", 8'(ld_err[1]), 8'h01);
    load(8'h07, 8'h30, 8'h00);
    check("alm_ld_none", 8'(alarm[1]), 8'h00);
    cyc(1);
    check("alm_after_ld", 8'(alarm[1]), 8'h00);
    load(8'h07, 8'h29, 8'h59);
    alm_ack = 1'b1;
    cyc(1);
    check("alm_set_wins", 8'(alarm[1]), 8'h01);
    cyc(1);
    alm_ack = 1'b0;
    check("alm_ack_late", 8'(alarm[1]), 8'h00);
    alm_en = 1'b0;

    // Enable freeze mid-second, then resume from the held count
    load(8'h00, 8'h00, 8'h00);
    cyc(2);
    en = 1'b0;
    cyc(10);
    check("frz_ss4", ss[0], 8'h00);
    check("frz_tick4", 8'(tick[0]), 8'h00);
    check("frz_ss1", ss[1], 8'h02);
    en = 1'b1;
    cyc(1);
    check("res_notick", 8'(tick[0]), 8'h00);
    cyc(1);
    check("res_tick", 8'(tick[0]), 8'h01);
    check("res_ss", ss[0], 8'h01);

    // Asynchronous reset mid-count
    load(8'h11, 8'h22, 8'h33);
    cyc(2);
    rst = 1'b0;
    #1;
    check("arst_hh", hh[0], 8'h00);
    check("arst_ss1", ss[1], 8'h00);
    cyc(1);
    rst = 1'b1;
    cyc(4);
    check("arst_tick", 8'(tick[0]), 8'h01);
    check("arst_ss4", ss[0], 8'h01);
    check("arst_fast", ss[1], 8'h04);

    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
